// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_fifo_ctrl : 16-entry FIFO sequencing a 1r1w SRAM macro, 2-entry ob    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_count_q, ob_count_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] ob_after_pop;
  logic [2:0] ob_pending;

  // Internal handshakes leave rst out; flops are held in reset anyway and
  // only the externally visible strobes are gated by it.
  assign push       = in_valid && !flush && (mem_count_q != DEPTH_CNT);
  assign out_valid  = (ob_count_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign ob_pending = {1'b0, ob_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = !flush && (mem_count_q != '0) && (ob_pending < 3'd2);

  assign in_ready   = !rst && !flush && (mem_count_q != DEPTH_CNT);
  assign sram_csb0  = !(push && !rst);
  assign sram_addr0 = wr_ptr_q;
  assign sram_din0  = in_data;
  assign sram_csb1  = !(issue && !rst);
  assign sram_addr1 = rd_ptr_q;
  assign out_data   = ob0_q;
  assign level      = mem_count_q + (ADDR_WIDTH+1)'(inflight_q)
                    + (ADDR_WIDTH+1)'(ob_count_q);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_count_d  = mem_count_q;
    inflight_d   = 1'b0;
    ob_count_d   = ob_count_q;
    ob0_d        = ob0_q;
    ob1_d        = ob1_q;
    ob_after_pop = ob_count_q - {1'b0, pop};

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      ob_count_d  = 2'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      inflight_d  = issue;
      mem_count_d = mem_count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);

      if (pop) begin
        ob0_d = ob1_q;
      end
      // Returning read data lands behind whatever survives this cycle's pop.
      if (inflight_q) begin
        if (ob_after_pop == 2'd0) begin
          ob0_d = sram_dout1;
        end else begin
          ob1_d = sram_dout1;
        end
      end
      ob_count_d = ob_after_pop + {1'b0, inflight_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
      ob_count_q  <= 2'd0;
      ob0_q       <= '0;
      ob1_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
      ob_count_q  <= ob_count_d;
      ob0_q       <= ob0_d;
      ob1_q       <= ob1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sram_fifo_ctrl : directed + randomized bench with a behavioural macro   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       sram_csb0;
  logic [3:0] sram_addr0;
  logic [7:0] sram_din0;
  logic       sram_csb1;
  logic [3:0] sram_addr1;
  logic [7:0] sram_dout1 = 8'h00;

  int checks = 0;
  int errors = 0;

  sram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 1r1w macro: sample at posedge, write/read at the following negedge.
  logic [7:0] mem [16];
  logic       s_csb0 = 1'b1;
  logic       s_csb1 = 1'b1;
  logic [3:0] s_a0 = 4'd0;
  logic [3:0] s_a1 = 4'd0;
  logic [7:0] s_d0 = 8'd0;

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
  end

  always @(posedge clk) begin
    s_csb0 <= sram_csb0;
    s_csb1 <= sram_csb1;
    s_a0   <= sram_addr0;
    s_a1   <= sram_addr1;
    s_d0   <= sram_din0;
  end

  always @(negedge clk) begin
    if (!s_csb0) mem[s_a0] <= s_d0;
    if (!s_csb1) sram_dout1 <= mem[s_a1];
  end

  // Both ports active in one cycle must never target the same address.
  always @(negedge clk) begin
    if (!sram_csb0 && !sram_csb1) begin
      checks++;
      assert (sram_addr0 !== sram_addr1) else begin
        errors++;
        $error("FAIL addr_collision observed addr0=0x%0h addr1=0x%0h required distinct",
               sram_addr0, sram_addr1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  int n;
  int pushed;
  int popped;
  int first_c;
  int last_c;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_csb0",      32'(sram_csb0), 1);
    chk("rst_csb1",      32'(sram_csb1), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_level",     32'(level), 0);
    rst = 1'b0;

    // Single word latency
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1; #1;
    chk("t1_c0_csb0",  32'(sram_csb0), 0);
    chk("t1_c0_addr0", 32'(sram_addr0), 0);
    chk("t1_c0_din0",  32'(sram_din0), 32'h11);
    chk("t1_c0_csb1",  32'(sram_csb1), 1);
    tick(); in_valid = 1'b0; #1;
    chk("t1_c1_csb1",  32'(sram_csb1), 0);
    chk("t1_c1_addr1", 32'(sram_addr1), 0);
    chk("t1_c1_level", 32'(level), 1);
    chk("t1_c1_ovld",  32'(out_valid), 0);
    tick(); #1;
    chk("t1_c2_level", 32'(level), 1);
    chk("t1_c2_ovld",  32'(out_valid), 0);
    tick(); #1;
    chk("t1_c3_ovld",  32'(out_valid), 1);
    chk("t1_c3_data",  32'(out_data), 32'h11);
    chk("t1_c3_level", 32'(level), 1);
    tick(); #1;
    chk("t1_c4_ovld",  32'(out_valid), 0);
    chk("t1_c4_level", 32'(level), 0);

    // Fill to full under backpressure, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_data = i[7:0]; #1;
      chk("t2_in_ready", 32'(in_ready), 1);
      tick();
    end
    in_data = 8'h55; #1;
    chk("t2_full_ready", 32'(in_ready), 0);
    chk("t2_full_csb0",  32'(sram_csb0), 1);
    chk("t2_full_level", 32'(level), 18);
    in_valid = 1'b0;
    tick(); #1;
    chk("t2_hold_level", 32'(level), 18);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 18; c++) begin
      #1;
      if (out_valid) begin
        chk("t2_pop_data", 32'(out_data), n);
        n++;
      end
      tick();
    end
    #1;
    chk("t2_pop_count", n, 18);
    chk("t2_end_level", 32'(level), 0);

    // Streaming 40 words, one pop per cycle after fill
    pushed = 0; popped = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 200 && popped < 40; c++) begin
      in_valid = (pushed < 40); in_data = 8'h80 + pushed[7:0]; out_ready = 1'b1; #1;
      if (in_valid) chk("t3_in_ready", 32'(in_ready), 1);
      if (in_valid && in_ready) pushed++;
      if (out_valid) begin
        chk("t3_data", 32'(out_data), 32'h80 + popped);
        if (first_c < 0) first_c = c;
        last_c = c;
        popped++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("t3_first_pop", first_c, 3);
    chk("t3_last_pop",  last_c, 42);

    // Random handshakes with scoreboard
    q.delete(); pushed = 0; popped = 0;
    for (int c = 0; c < 6000 && popped < 500; c++) begin
      in_valid  = (pushed < 500) && ($urandom % 2 == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom % 2 == 1);
      #1;
      chk("t4_level", 32'(level), q.size());
      if (out_valid && out_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk("t4_data", 32'(out_data), 32'(exp_d));
        popped++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        pushed++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_pop_count", popped, 500);

    // Flush with a read in flight and a buffered word
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h21 + i[7:0];
      tick();
    end
    in_valid = 1'b1; in_data = 8'h77; flush = 1'b1; #1;
    chk("t5_pre_level", 32'(level), 3);
    chk("t5_pre_ovld",  32'(out_valid), 1);
    chk("t5_fl_ready",  32'(in_ready), 0);
    chk("t5_fl_csb0",   32'(sram_csb0), 1);
    chk("t5_fl_csb1",   32'(sram_csb1), 1);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("t5_post_ovld",  32'(out_valid), 0);
    chk("t5_post_level", 32'(level), 0);
    in_valid = 1'b1; in_data = 8'hA5; #1;
    chk("t5_push_csb0",  32'(sram_csb0), 0);
    chk("t5_push_addr0", 32'(sram_addr0), 0);
    tick(); in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("t5_p1_ovld", 32'(out_valid), 0);
    tick(); #1;
    chk("t5_p2_ovld", 32'(out_valid), 0);
    tick(); #1;
    chk("t5_p3_ovld", 32'(out_valid), 1);
    chk("t5_p3_data", 32'(out_data), 32'hA5);
    tick(); #1;
    chk("t5_end_level", 32'(level), 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h31 + i[7:0];
      tick();
    end
    in_valid = 1'b1; in_data = 8'h35; #1;
    chk("t6_pre_ovld", 32'(out_valid), 1);
    chk("t6_pre_csb0", 32'(sram_csb0), 0);
    #1; rst = 1'b1; #1;
    chk("t6_rst_ovld",  32'(out_valid), 0);
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_ready", 32'(in_ready), 0);
    chk("t6_rst_csb0",  32'(sram_csb0), 1);
    chk("t6_rst_csb1",  32'(sram_csb1), 1);
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1; #1;
    chk("t6_rel_csb0",  32'(sram_csb0), 0);
    chk("t6_rel_addr0", 32'(sram_addr0), 0);
    tick(); in_valid = 1'b0;
    tick(); tick(); #1;
    chk("t6_rel_ovld", 32'(out_valid), 1);
    chk("t6_rel_data", 32'(out_data), 32'h3C);
    tick(); #1;
    chk("t6_end_level", 32'(level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
